// File: rtl/video_frame_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : video_frame_monitor
// Brief   : Locks to vsync, skips/captures frames as an x/y pixel stream and
//           measures per-frame geometry, checksum and sticky sync errors.
// Rev     : 1.0  initial release
// ============================================================================
module video_frame_monitor #(
  parameter int DATA_WIDTH  = 24,
  parameter int IMG_WIDTH   = 1280,
  parameter int IMG_HEIGHT  = 720,
  parameter int SKIP_FRAMES = 0,
  parameter int CAP_FRAMES  = 1,
  parameter int VS_POL      = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  video_clk,
  input  logic                  rst_n,
  input  logic                  video_vs,
  input  logic                  video_de,
  input  logic [DATA_WIDTH-1:0] video_data,
  output logic                  cap_valid,
  output logic [DATA_WIDTH-1:0] cap_data,
  output logic [CNT_W-1:0]      cap_x,
  output logic [CNT_W-1:0]      cap_y,
  output logic                  cap_sof,
  output logic                  frame_done,
  output logic [7:0]            frame_idx,
  output logic [31:0]           checksum,
  output logic [CNT_W-1:0]      meas_width,
  output logic [CNT_W-1:0]      meas_height,
  output logic                  err_width,
  output logic                  err_height,
  output logic                  err_sync,
  output logic                  cap_done
);

  localparam logic [CNT_W-1:0] c_img_w     = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] c_img_h     = CNT_W'(IMG_HEIGHT);
  localparam logic [31:0]      c_skip_last = 32'(SKIP_FRAMES - 1);
  localparam logic [31:0]      c_cap_last  = 32'(CAP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SKIP    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_vs_d;
  logic              r_de_d;
  logic              r_sof_pend;
  logic [31:0]       r_skip_cnt;
  logic [31:0]       r_cap_cnt;
  logic [CNT_W-1:0]  r_x_cnt;
  logic [CNT_W-1:0]  r_y_cnt;
  logic [CNT_W-1:0]  r_line_len;
  logic [31:0]       r_sum;

  logic              w_vs_act;
  logic              w_sync_end;
  logic              w_in_cap;
  logic              w_accept;
  logic              w_line_end;
  logic              w_frame_end;
  logic              w_last_frame;
  logic [CNT_W-1:0]  w_x_inc;
  logic [CNT_W-1:0]  w_line_cnt;
  logic [CNT_W-1:0]  w_last_len;
  logic [31:0]       w_pix32;

  assign w_vs_act     = (VS_POL != 0) ? video_vs : ~video_vs;
  assign w_sync_end   = r_vs_d & ~w_vs_act;
  assign w_in_cap     = (r_state == ST_CAPTURE);
  assign w_accept     = w_in_cap & video_de & ~w_vs_act;
  assign w_line_end   = w_in_cap & r_de_d & ~w_accept;
  assign w_frame_end  = w_in_cap & w_sync_end;
  assign w_last_frame = (CAP_FRAMES != 0) && (r_cap_cnt == c_cap_last);
  assign w_x_inc      = (r_x_cnt == '1) ? r_x_cnt : r_x_cnt + CNT_W'(1);
  // A line closing on the boundary cycle still belongs to the ending frame
  assign w_line_cnt   = r_y_cnt + CNT_W'(w_line_end);
  assign w_last_len   = w_line_end ? r_x_cnt : r_line_len;
  assign w_pix32      = 32'(video_data);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_sync_end) w_state_nxt = (SKIP_FRAMES > 0) ? ST_SKIP : ST_CAPTURE;
      ST_SKIP:    if (w_sync_end && (r_skip_cnt == c_skip_last)) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (w_sync_end && w_last_frame) w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_DONE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vs_d     <= 1'b0;
      r_skip_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_vs_d  <= w_vs_act;
      if (r_state == ST_IDLE)
        r_skip_cnt <= '0;
      else if ((r_state == ST_SKIP) && w_sync_end)
        r_skip_cnt <= r_skip_cnt + 32'd1;
    end
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de_d      <= 1'b0;
      r_sof_pend  <= 1'b1;
      r_cap_cnt   <= '0;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_line_len  <= '0;
      r_sum       <= '0;
      cap_valid   <= 1'b0;
      cap_data    <= '0;
      cap_x       <= '0;
      cap_y       <= '0;
      cap_sof     <= 1'b0;
      frame_done  <= 1'b0;
      frame_idx   <= '0;
      checksum    <= '0;
      meas_width  <= '0;
      meas_height <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
      err_sync    <= 1'b0;
      cap_done    <= 1'b0;
    end else begin
      r_de_d     <= w_accept;
      cap_valid  <= w_accept;
      cap_sof    <= w_accept & (r_sof_pend | w_frame_end);
      frame_done <= w_frame_end;
      if (w_accept) begin
        cap_data <= video_data;
        cap_x    <= w_frame_end ? '0 : r_x_cnt;
        cap_y    <= w_frame_end ? '0 : r_y_cnt;
      end

      if (w_in_cap && video_de && w_vs_act)
        err_sync <= 1'b1;
      if (w_line_end && (r_x_cnt != c_img_w))
        err_width <= 1'b1;

      if (w_frame_end) begin
        meas_width  <= w_last_len;
        meas_height <= w_line_cnt;
        checksum    <= r_sum;
        frame_idx   <= frame_idx + 8'd1;
        r_cap_cnt   <= r_cap_cnt + 32'd1;
        if (w_line_cnt != c_img_h)
          err_height <= 1'b1;
        if (w_last_frame)
          cap_done <= 1'b1;
        // A pixel on the boundary cycle opens the next frame
        r_y_cnt    <= '0;
        r_line_len <= '0;
        r_x_cnt    <= w_accept ? CNT_W'(1) : '0;
        r_sum      <= w_accept ? w_pix32 : '0;
        r_sof_pend <= ~w_accept;
      end else begin
        if (w_accept) begin
          r_x_cnt    <= w_x_inc;
          r_sum      <= r_sum + w_pix32;
          r_sof_pend <= 1'b0;
        end else if (w_line_end) begin
          r_x_cnt    <= '0;
          r_y_cnt    <= r_y_cnt + CNT_W'(1);
          r_line_len <= r_x_cnt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_frame_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_video_frame_monitor
// Brief   : Two monitors (VS_POL=1/SKIP 0/CAP 1 and VS_POL=0/SKIP 1/CAP 2) on
//           one randomized stream, checked against a frame-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_video_frame_monitor;
  localparam int DW = 24;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int CW = 16;

  logic          video_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic          vs_act    = 1'b0;
  logic          de        = 1'b0;
  logic [DW-1:0] data      = '0;
  logic          vs_n;
  assign vs_n = ~vs_act;

  always #5 video_clk = ~video_clk;

  logic          cap_valid   [2];
  logic [DW-1:0] cap_data    [2];
  logic [CW-1:0] cap_x       [2];
  logic [CW-1:0] cap_y       [2];
  logic          cap_sof     [2];
  logic          frame_done  [2];
  logic [7:0]    frame_idx   [2];
  logic [31:0]   checksum    [2];
  logic [CW-1:0] meas_width  [2];
  logic [CW-1:0] meas_height [2];
  logic          err_width   [2];
  logic          err_height  [2];
  logic          err_sync    [2];
  logic          cap_done    [2];

  video_frame_monitor #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(0),
                        .CAP_FRAMES(1), .VS_POL(1), .CNT_W(CW)) u_a (
    .video_clk(video_clk), .rst_n(rst_n), .video_vs(vs_act), .video_de(de), .video_data(data),
    .cap_valid(cap_valid[0]), .cap_data(cap_data[0]), .cap_x(cap_x[0]), .cap_y(cap_y[0]),
    .cap_sof(cap_sof[0]), .frame_done(frame_done[0]), .frame_idx(frame_idx[0]),
    .checksum(checksum[0]), .meas_width(meas_width[0]), .meas_height(meas_height[0]),
    .err_width(err_width[0]), .err_height(err_height[0]), .err_sync(err_sync[0]),
    .cap_done(cap_done[0]));

  video_frame_monitor #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SKIP_FRAMES(1),
                        .CAP_FRAMES(2), .VS_POL(0), .CNT_W(CW)) u_b (
    .video_clk(video_clk), .rst_n(rst_n), .video_vs(vs_n), .video_de(de), .video_data(data),
    .cap_valid(cap_valid[1]), .cap_data(cap_data[1]), .cap_x(cap_x[1]), .cap_y(cap_y[1]),
    .cap_sof(cap_sof[1]), .frame_done(frame_done[1]), .frame_idx(frame_idx[1]),
    .checksum(checksum[1]), .meas_width(meas_width[1]), .meas_height(meas_height[1]),
    .err_width(err_width[1]), .err_height(err_height[1]), .err_sync(err_sync[1]),
    .cap_done(cap_done[1]));

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          sof;
  } pix_t;

  typedef struct packed {
    logic [CW-1:0] w;
    logic [CW-1:0] h;
    logic [31:0]   cks;
    logic [7:0]    idx;
    logic          done;
    logic [2:0]    errs;
  } res_t;

  pix_t pix_q [2][$];
  res_t res_q [2][$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference model: per DUT, boundaries since reset decide capture
  int          nb    [2];
  int          ncap  [2];
  bit          capt  [2];
  bit          done_m[2];
  bit          ew    [2];
  bit          eh    [2];
  bit          es    [2];
  logic [7:0]  fidx  [2];
  logic [31:0] fsum;
  int          flines;
  int          flast;
  int          fpix;

  function automatic int skip_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int cap_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      nb[d] = 0; ncap[d] = 0; capt[d] = 0; done_m[d] = 0;
      ew[d] = 0; eh[d] = 0; es[d] = 0; fidx[d] = '0;
      pix_q[d].delete();
      res_q[d].delete();
    end
  endtask

  task automatic model_boundary();
    res_t r;
    for (int d = 0; d < 2; d++) begin
      if (capt[d]) begin
        ncap[d]++;
        fidx[d] = fidx[d] + 8'd1;
        if (flines != H) eh[d] = 1;
        if (ncap[d] == cap_of(d)) done_m[d] = 1;
        r.w = CW'(flast); r.h = CW'(flines); r.cks = fsum; r.idx = fidx[d];
        r.done = done_m[d]; r.errs = {ew[d], eh[d], es[d]};
        res_q[d].push_back(r);
      end
      nb[d]++;
      capt[d] = (nb[d] - 1 >= skip_of(d)) && (nb[d] - 1 - skip_of(d) < cap_of(d));
    end
    fsum = '0; flines = 0; flast = 0; fpix = 0;
  endtask

  task automatic model_pixel(input logic [DW-1:0] dv, input int x, input int y);
    pix_t p;
    p.data = dv; p.x = CW'(x); p.y = CW'(y); p.sof = (fpix == 0);
    for (int d = 0; d < 2; d++)
      if (capt[d]) pix_q[d].push_back(p);
    fsum = fsum + 32'(dv);
    fpix++;
  endtask

  task automatic model_line(input int len);
    flines++;
    flast = len;
    for (int d = 0; d < 2; d++)
      if (capt[d] && len != W) ew[d] = 1;
  endtask

  function automatic logic any_out(input int d);
    return |{cap_valid[d], cap_data[d], cap_x[d], cap_y[d], cap_sof[d], frame_done[d],
             frame_idx[d], checksum[d], meas_width[d], meas_height[d], err_width[d],
             err_height[d], err_sync[d], cap_done[d]};
  endfunction

  task automatic drive(input logic v, input logic e, input logic [DW-1:0] dv);
    @(posedge video_clk);
    #1;
    vs_act = v; de = e; data = dv;
  endtask

  task automatic do_reset();
    @(posedge video_clk);
    #1;
    rst_n = 1'b0; de = 1'b0; vs_act = 1'b0;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("midreset_zero%0d", d), any_out(d), 0);
    repeat (2) @(posedge video_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic vsync(input bit pulse);
    for (int i = 0; i < 4; i++) drive(1'b1, pulse && (i == 1), DW'($urandom));
    if (pulse)
      for (int d = 0; d < 2; d++) if (capt[d]) es[d] = 1;
    drive(1'b0, 1'b0, '0);
    model_boundary();
    drive(1'b0, 1'b0, '0);
  endtask

  // mode: 0 random lengths/data, 1 nominal lengths random data, 2 nominal index data
  task automatic active(input int nl, input int short_l, input int mode,
                        input int rst_l, input int rst_px);
    int cnt;
    int len;
    logic [DW-1:0] dv;
    cnt = 0;
    for (int l = 0; l < nl; l++) begin
      if (l == short_l) len = W - 1;
      else if (mode != 0) len = W;
      else len = ($urandom_range(0, 9) < 7) ? W : int'($urandom_range(W - 1, W + 1));
      for (int p = 0; p < len; p++) begin
        dv = (mode == 2) ? DW'(cnt) : DW'($urandom);
        drive(1'b0, 1'b1, dv);
        model_pixel(dv, p, l);
        cnt++;
        if (l == rst_l && p == rst_px) do_reset();
      end
      model_line(len);
      repeat (2) drive(1'b0, 1'b0, '0);
    end
  endtask

  always @(negedge video_clk) begin : mon
    pix_t pe;
    res_t re;
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (cap_valid[d]) begin
          if (pix_q[d].size() == 0) check($sformatf("pix_extra%0d", d), 1, 0);
          else begin
            pe = pix_q[d].pop_front();
            check($sformatf("pix_data%0d", d), cap_data[d], pe.data);
            check($sformatf("pix_x%0d", d), cap_x[d], pe.x);
            check($sformatf("pix_y%0d", d), cap_y[d], pe.y);
            check($sformatf("pix_sof%0d", d), cap_sof[d], pe.sof);
          end
        end else if (cap_sof[d]) begin
          check($sformatf("sof_no_valid%0d", d), 1, 0);
        end
        if (frame_done[d]) begin
          if (res_q[d].size() == 0) check($sformatf("fd_extra%0d", d), 1, 0);
          else begin
            re = res_q[d].pop_front();
            check($sformatf("meas_w%0d", d), meas_width[d], re.w);
            check($sformatf("meas_h%0d", d), meas_height[d], re.h);
            check($sformatf("cksum%0d", d), checksum[d], re.cks);
            check($sformatf("fidx%0d", d), frame_idx[d], re.idx);
            check($sformatf("done%0d", d), cap_done[d], re.done);
            check($sformatf("errs%0d", d), {err_width[d], err_height[d], err_sync[d]}, re.errs);
          end
        end
      end
    end
  end

  initial begin
    model_clear();
    fsum = '0; flines = 0; flast = 0; fpix = 0;
    repeat (3) @(posedge video_clk);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("reset_zero%0d", d), any_out(d), 0);
    rst_n = 1'b1;

    active(2, -1, 2, -1, -1);                          // before any vsync: ignored
    vsync(0); active(4, -1, 2, -1, -1);                // F0: u_a captures index frame
    vsync(0); active(int'($urandom_range(0, 5)), -1, 0, -1, -1);  // F1: u_b first capture
    vsync(1); active(4, -1, 1, 1, 3);                  // F2: reset mid-line
    vsync(0); active(4, -1, 2, -1, -1);                // F3: relock, u_a index frame
    vsync(0); active(4, 1, 1, -1, -1);                 // F4: second line short
    vsync(1); active(3, -1, 1, -1, -1);                // F5: three lines
    vsync(0); active(int'($urandom_range(0, 5)), -1, 0, -1, -1);
    vsync(0); active(0, -1, 0, -1, -1);
    vsync(0);
    repeat (6) drive(1'b0, 1'b0, '0);

    for (int d = 0; d < 2; d++) begin
      check($sformatf("end_fidx%0d", d), frame_idx[d], fidx[d]);
      check($sformatf("end_done%0d", d), cap_done[d], done_m[d]);
      check($sformatf("end_errs%0d", d), {err_width[d], err_height[d], err_sync[d]},
            {ew[d], eh[d], es[d]});
      check($sformatf("pix_missing%0d", d), pix_q[d].size(), 0);
      check($sformatf("fd_missing%0d", d), res_q[d].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
